frame_serializer: RTL
=====================

// Module: frame_serializer
// PURPOSE
//  Parametrised parallel-to-serial transmitter for SAP-3 off-chip/debug links.
//  - Accepts WIDTH-bit words over a valid/ready handshake.
//  - Emits each word over LANES serial lines, preceded by a one-cycle start sync pulse.
//  - Optional MSB-first ordering and a per-lane parity beat.
//  - Sits between the core's parallel output registers and the pad ring; the matching deserializer syncs on start.
// PARAMETERS
//  WIDTH      8  data word width; WIDTH % LANES == 0 (elaboration $error otherwise)
//  LANES      1  number of parallel serial lines; BEATS = WIDTH/LANES
//  MSB_FIRST  0  0: beat 0 carries the lowest bits; 1: beat 0 carries the highest bits
//  PARITY_EN  0  1: one extra beat after data carrying per-lane even parity
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      reset, asynchronous, active-high
//  data_in     in   WIDTH  parallel word, sampled when in_valid && in_ready
//  in_valid    in   1      producer has a word
//  in_ready    out  1      serializer can accept a word this cycle
//  serial_out  out  LANES  serial data, registered
//  start       out  1      sync pulse, registered, high exactly one cycle per frame
//  busy        out  1      registered, high from the start cycle through the last beat
// BEHAVIOUR
//  Reset: async; state=IDLE, beat counter=0, shadow=0, serial_out=0, start=0, busy=0.
//   - in_ready forced 0 while rst is high.
//  States: IDLE -> START -> SEND -> (PARITY if PARITY_EN) -> IDLE, or directly -> START.
//   - IDLE: in_ready=1. On handshake at edge T, capture data_in into shadow.
//     Next state START; start=1 and busy=1 during cycle T+1.
//   - START: serial_out=0; go SEND; beat counter=0.
//   - SEND: cycles T+2 .. T+1+BEATS each present beat k (k=0..BEATS-1).
//     Lane l at beat k drives:
//       MSB_FIRST=0: shadow[k*LANES+l]
//       MSB_FIRST=1: shadow[(BEATS-1-k)*LANES+l]
//   - PARITY: one cycle; lane l = XOR of every bit that lane carried in the frame.
//  Last beat: final SEND beat (PARITY_EN=0) or the PARITY beat.
//   - in_ready=1 (combinational from state and counter) during the last beat.
//   - Handshake on the last beat: shadow reloads, next cycle is START (start=1).
//     No idle gap; frame period = BEATS+1+PARITY_EN cycles.
//   - No handshake on the last beat: next state IDLE, serial_out=0, busy=0.
//  Latency: handshake edge T -> start high at T+1 -> first data beat at T+2.
//  serial_out is 0 in IDLE and START (no hold of the previous bit).
//  data_in changes after the handshake do not affect the frame in flight.
//  in_valid low in IDLE: stay IDLE, all outputs quiescent.
//  Beat counter width max(1,$clog2(BEATS)); wraps to 0 only via the START state.
//  BEATS=1 (LANES==WIDTH): SEND lasts one cycle; that beat is the last beat when PARITY_EN=0.
//  Reset mid-frame: frame discarded, outputs 0 immediately.
//   - No further start or beats; first handshake possible on the first edge after release.
//  Illegal state encoding: recover to IDLE, outputs 0.
// STRUCTURE
//  Shared package sap3_ser_pkg:
//   - typedef enum logic [1:0] {SER_IDLE, SER_START, SER_SEND, SER_PARITY} ser_state_t
//   - function beat_slice(shadow, k, msb_first) returning a LANES-wide slice
//   - the deserializer imports the same package
//  Single module: FSM + counter + shadow register + per-lane parity accumulators.
//  No sub-module; the lane slice mux is a package function.
// TESTING
//  1. W8 L1 LSB, 0xA5 handshake at T -> start@T+1; serial 1,0,1,0,0,1,0,1 @T+2..T+9; busy low @T+10.
//  2. W8 L2, 0xB4 -> beats 2'b00, 2'b01, 2'b11, 2'b10; start single-cycle; in_ready=0 in beats 0-2.
//  3. W8 L1 MSB_FIRST=1, 0x80 -> serial 1 then seven 0s; PARITY_EN=1 with 0x07 (LSB) -> parity beat = 1.
//  4. in_valid held high, data 0x01 then 0x02 -> second start in the cycle right after the
//     first frame's last beat; start-to-start period 9 (L1, no parity); no dropped or duplicated word.
//  5. rst asserted asynchronously during beat 3 -> serial_out/start/busy 0 at once, in_ready 0 while rst.
//     After release: IDLE, in_ready 1, clean frame on next handshake.
//  6. W4 L4 PARITY_EN=1, 0xF -> start, one data beat 4'hF, parity beat 4'hF, next cycle IDLE.

Source files
------------

// File: rtl/sap3_ser_pkg.sv
// Shared types and helpers for the SAP-3 serial link (serializer and deserializer).
package sap3_ser_pkg;

    // Upper bounds for the generic slice helper; instances must fit inside these.
    localparam int unsigned SER_MAX_WIDTH = 64;
    localparam int unsigned SER_MAX_LANES = 64;

    typedef enum logic [1:0] {
        SER_IDLE   = 2'd0,
        SER_START  = 2'd1,
        SER_SEND   = 2'd2,
        SER_PARITY = 2'd3
    } ser_state_t;

    typedef logic [SER_MAX_WIDTH-1:0] ser_word_t;
    typedef logic [SER_MAX_LANES-1:0] ser_slice_t;

    // Returns the lanes carried on beat k; only the low 'lanes' bits are meaningful.
    function automatic ser_slice_t beat_slice(
        input ser_word_t   shadow,
        input int unsigned k,
        input logic        msb_first,
        input int unsigned lanes,
        input int unsigned beats
    );
        int unsigned base;
        ser_slice_t  mask;
        base = msb_first ? (beats - 1 - k) * lanes : k * lanes;
        mask = (lanes >= SER_MAX_LANES) ? '1
                                        : ((ser_slice_t'(1) << lanes) - ser_slice_t'(1));
        return ser_slice_t'(shadow >> base) & mask;
    endfunction

endpackage

// File: rtl/frame_serializer.sv
// Parallel-to-serial transmitter: start pulse, BEATS data beats over LANES lines,
// optional per-lane even-parity beat, back-to-back frames without idle gap.
module frame_serializer
    import sap3_ser_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LANES     = 1,
    parameter bit          MSB_FIRST = 1'b0,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [LANES-1:0] serial_out,
    output logic             start,
    output logic             busy
);

    localparam int unsigned BEATS = WIDTH / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    localparam logic [1:0] ST_IDLE   = SER_IDLE;
    localparam logic [1:0] ST_START  = SER_START;
    localparam logic [1:0] ST_SEND   = SER_SEND;
    localparam logic [1:0] ST_PARITY = SER_PARITY;

    // Configuration sanity checks at elaboration
    if ((WIDTH % LANES) != 0) begin : g_bad_lanes
        $error("frame_serializer: WIDTH (%0d) is not a multiple of LANES (%0d)", WIDTH, LANES);
    end
    if ((WIDTH > SER_MAX_WIDTH) || (LANES > SER_MAX_LANES)) begin : g_too_wide
        $error("frame_serializer: WIDTH/LANES exceed sap3_ser_pkg limits");
    end

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shadow;
    logic [LANES-1:0] r_par;
    logic [LANES-1:0] r_serial;
    logic             r_start;
    logic             r_busy;

    logic [1:0]       w_state_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [WIDTH-1:0] w_shadow_nx;
    logic [LANES-1:0] w_par_nx;
    logic [LANES-1:0] w_serial_nx;
    logic             w_start_nx;
    logic             w_busy_nx;

    logic             w_last;
    logic             w_hs;
    logic [CNT_W-1:0] w_beat_sel;
    logic [LANES-1:0] w_slice;

    // Last beat of a frame: the final data beat, or the parity beat when enabled
    assign w_last = ((r_state == ST_SEND) && (r_cnt == LAST_CNT) && !PARITY_EN)
                  || (r_state == ST_PARITY);

    // Ready in IDLE or on the last beat so frames can run back to back
    assign in_ready = !rst && ((r_state == ST_IDLE) || w_last);
    assign w_hs     = in_valid && in_ready;

    // Beat index that will be on the lines next cycle: 0 after START, else current+1
    assign w_beat_sel = ((r_state == ST_SEND) && (r_cnt != LAST_CNT)) ? (r_cnt + CNT_W'(1))
                                                                       : '0;

    assign w_slice = LANES'(beat_slice(SER_MAX_WIDTH'(r_shadow), 32'(w_beat_sel),
                                       MSB_FIRST, LANES, BEATS));

    // Next-state and next-output logic; outputs are registered with the state
    always_comb begin
        w_state_nx  = ST_IDLE;
        w_cnt_nx    = r_cnt;
        w_shadow_nx = r_shadow;
        w_par_nx    = r_par;
        w_serial_nx = '0;
        w_start_nx  = 1'b0;
        w_busy_nx   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_hs) begin
                    w_shadow_nx = data_in;
                    w_state_nx  = ST_START;
                    w_cnt_nx    = '0;
                    w_start_nx  = 1'b1;
                    w_busy_nx   = 1'b1;
                end
            end

            ST_START: begin
                w_state_nx  = ST_SEND;
                w_cnt_nx    = '0;
                w_serial_nx = w_slice;
                w_par_nx    = w_slice;
                w_busy_nx   = 1'b1;
            end

            ST_SEND: begin
                if (r_cnt != LAST_CNT) begin
                    w_state_nx  = ST_SEND;
                    w_cnt_nx    = w_beat_sel;
                    w_serial_nx = w_slice;
                    w_par_nx    = r_par ^ w_slice;
                    w_busy_nx   = 1'b1;
                end else if (PARITY_EN) begin
                    w_state_nx  = ST_PARITY;
                    w_serial_nx = r_par;
                    w_busy_nx   = 1'b1;
                end else if (w_hs) begin
                    w_shadow_nx = data_in;
                    w_state_nx  = ST_START;
                    w_cnt_nx    = '0;
                    w_start_nx  = 1'b1;
                    w_busy_nx   = 1'b1;
                end
            end

            ST_PARITY: begin
                if (w_hs) begin
                    w_shadow_nx = data_in;
                    w_state_nx  = ST_START;
                    w_cnt_nx    = '0;
                    w_start_nx  = 1'b1;
                    w_busy_nx   = 1'b1;
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_par    <= '0;
            r_serial <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_cnt    <= w_cnt_nx;
            r_shadow <= w_shadow_nx;
            r_par    <= w_par_nx;
            r_serial <= w_serial_nx;
            r_start  <= w_start_nx;
            r_busy   <= w_busy_nx;
        end
    end

    assign serial_out = r_serial;
    assign start      = r_start;
    assign busy       = r_busy;

endmodule
